// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a switch-level 4:1 mux: walks the selects, waits out the
// settle time, samples w per channel and presents the packed word on valid/ready.
`timescale 1ns/1ps

module mux_scan_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       continuous,
   input  logic       mux_w,
   input  logic       ready,
   output logic       s1,
   output logic       s0,
   output logic [3:0] data,
   output logic       valid,
   output logic       busy,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state;
   state_t           state_next;
   logic [1:0]       idx;
   logic [1:0]       idx_next;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] counter_next;
   logic [3:0]       shadow;
   logic [3:0]       shadow_next;
   logic [3:0]       data_next;
   logic             valid_next;
   logic             busy_next;
   logic             err_next;
   logic             sample_bit;
   logic             sample_bad;

   // Anything other than a clean 0/1 on w (X or Z) is stored as 0 and flagged.
   assign sample_bit = (mux_w === 1'b1);
   assign sample_bad = (mux_w !== 1'b0) && (mux_w !== 1'b1);

   assign s1 = idx[1];
   assign s0 = idx[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         idx     <= 2'd0;
         counter <= '0;
         shadow  <= 4'd0;
         data    <= 4'd0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_next;
         idx     <= idx_next;
         counter <= counter_next;
         shadow  <= shadow_next;
         data    <= data_next;
         valid   <= valid_next;
         busy    <= busy_next;
         err     <= err_next;
      end
   end

   always_comb begin
      state_next   = state;
      idx_next     = idx;
      counter_next = counter;
      shadow_next  = shadow;
      data_next    = data;
      valid_next   = valid;
      err_next     = err;

      unique case (state)
         IDLE: begin
            if (start) begin
               idx_next     = 2'd0;
               counter_next = RELOAD;
               err_next     = 1'b0;
               state_next   = SETTLE;
            end
         end

         SETTLE: begin
            if (counter == '0) begin
               state_next = SAMPLE;
            end else begin
               counter_next = counter - 1'b1;
            end
         end

         SAMPLE: begin
            shadow_next[idx] = sample_bit;
            if (sample_bad) begin
               err_next = 1'b1;
            end
            // The last channel goes straight into the word; idx parks at 3 until handoff.
            if (idx != 2'd3) begin
               idx_next     = idx + 2'd1;
               counter_next = RELOAD;
               state_next   = SETTLE;
            end else begin
               data_next  = {sample_bit, shadow[2:0]};
               valid_next = 1'b1;
               state_next = DONE;
            end
         end

         DONE: begin
            if (ready) begin
               valid_next = 1'b0;
               idx_next   = 2'd0;
               if (continuous) begin
                  err_next     = 1'b0;
                  counter_next = RELOAD;
                  state_next   = SETTLE;
               end else begin
                  state_next = IDLE;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: a behavioural 4:1 mux drives w from the
// DUT selects, and each scan is checked for select order, latency and word content.
`timescale 1ns/1ps

module tb_mux_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       continuous;
   logic       ready;
   logic       s1;
   logic       s0;
   logic [3:0] data;
   logic       valid;
   logic       busy;
   logic       err;
   logic [3:0] chanVal;
   logic [3:0] chanZ;
   wire        muxW;
   int         testsRun = 0;
   int         testsFailed = 0;
   int         cyc;
   bit         sawZ;

   always #5 clk = ~clk;

   // Channel value {d,c,b,a}; a set bit in chanZ tri-states that channel.
   assign muxW = chanZ[{s1, s0}] ? 1'bz : chanVal[{s1, s0}];

   mux_scan_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .continuous (continuous),
      .mux_w      (muxW),
      .s1         (s1),
      .s0         (s0),
      .data       (data),
      .valid      (valid),
      .ready      (ready),
      .busy       (busy),
      .err        (err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit cont, input bit rdy, input logic [3:0] vals, input logic [3:0] zs);
      continuous = cont;
      ready      = rdy;
      chanVal    = vals;
      chanZ      = zs;
   endtask

   // Called at a falling edge; returns at the falling edge after the accepting edge.
   task automatic pulseStart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts edges until valid, optionally checking the select sequence and
   // pulsing start at a chosen cycle; bounded so a stuck DUT still terminates.
   task automatic waitValid(input bit checkSel, input int startAt, output int count);
      count = 0;
      while (valid !== 1'b1 && count < 40) begin
         if (checkSel) checkOutput("selSequence", {30'd0, s1, s0}, count / 3);
         if ({s1, s0} == 2'd1 && muxW !== 1'b0 && muxW !== 1'b1) sawZ = 1'b1;
         start = (count == startAt);
         @(negedge clk);
         count++;
      end
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      sawZ  = 1'b0;
      applyStimulus(1'b0, 1'b1, 4'b1101, 4'b0000);
      #12;
      checkOutput("resetSel",   {30'd0, s1, s0}, 0);
      checkOutput("resetData",  data, 4'd0);
      checkOutput("resetValid", valid, 0);
      checkOutput("resetBusy",  busy, 0);
      checkOutput("resetErr",   err, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // One-shot scan of a,b,c,d = 1,0,1,1 with ready held high.
      pulseStart();
      waitValid(1'b1, -1, cyc);
      checkOutput("t1Latency", cyc, 12);
      checkOutput("t1Data",    data, 4'b1101);
      checkOutput("t1Err",     err, 0);
      checkOutput("t1SelAtDone", {30'd0, s1, s0}, 3);
      checkOutput("t1BusyAtDone", busy, 1);
      @(negedge clk);
      checkOutput("t1ValidAfter", valid, 0);
      checkOutput("t1BusyAfter",  busy, 0);
      checkOutput("t1SelAfter",   {30'd0, s1, s0}, 0);

      // Backpressure: word must hold while ready is low.
      ready = 1'b0;
      pulseStart();
      waitValid(1'b0, -1, cyc);
      checkOutput("t2Latency", cyc, 12);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("t2HoldData",  data, 4'b1101);
         checkOutput("t2HoldValid", valid, 1);
         checkOutput("t2HoldBusy",  busy, 1);
      end
      ready = 1'b1;
      @(negedge clk);
      checkOutput("t2ValidAfter", valid, 0);
      checkOutput("t2BusyAfter",  busy, 0);
      pulseStart();
      checkOutput("t2Restart", busy, 1);
      waitValid(1'b0, -1, cyc);
      checkOutput("t2Latency2", cyc, 12);
      @(negedge clk);

      // Continuous: second scan starts on the accepting edge with new inputs.
      continuous = 1'b1;
      pulseStart();
      waitValid(1'b0, -1, cyc);
      checkOutput("t3Latency1", cyc, 12);
      checkOutput("t3Data1",    data, 4'b1101);
      chanVal = 4'b0110;
      @(negedge clk);
      checkOutput("t3ValidAccept", valid, 0);
      checkOutput("t3SelRestart",  {30'd0, s1, s0}, 0);
      checkOutput("t3BusyRestart", busy, 1);
      continuous = 1'b0;
      waitValid(1'b1, -1, cyc);
      checkOutput("t3Latency2", cyc, 12);
      checkOutput("t3Data2",    data, 4'b0110);
      @(negedge clk);
      checkOutput("t3IdleAfter", busy, 0);
      continuous = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("t3ContIdle", busy, 0);
      continuous = 1'b0;

      // Reset during channel 2 settle clears outputs without a clock edge.
      chanVal = 4'b1101;
      pulseStart();
      repeat (7) @(negedge clk);
      checkOutput("t4SelBefore", {30'd0, s1, s0}, 2);
      #2 rst = 1'b0;
      #1;
      checkOutput("t4RstSel",   {30'd0, s1, s0}, 0);
      checkOutput("t4RstData",  data, 4'd0);
      checkOutput("t4RstValid", valid, 0);
      checkOutput("t4RstBusy",  busy, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t4IdleAfterRst", busy, 0);
      pulseStart();
      waitValid(1'b1, -1, cyc);
      checkOutput("t4Latency", cyc, 12);
      checkOutput("t4Data",    data, 4'b1101);
      checkOutput("t4Err",     err, 0);
      @(negedge clk);

      // Channel 1 tri-stated: bit 1 reads 0 and err flags the bad sample.
      applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0010);
      sawZ = 1'b0;
      pulseStart();
      waitValid(1'b0, -1, cyc);
      checkOutput("t5Latency", cyc, 12);
      checkOutput("t5Data",    data, 4'b1101);
      checkOutput("t5Err",     err, {31'd0, sawZ});
      @(negedge clk);
      checkOutput("t5ErrSticky", err, {31'd0, sawZ});
      checkOutput("t5ValidAfter", valid, 0);
      chanZ = 4'b0000;
      pulseStart();
      checkOutput("t5ErrCleared", err, 0);
      waitValid(1'b0, -1, cyc);
      checkOutput("t5Data2", data, 4'b1111);
      checkOutput("t5Err2",  err, 0);
      @(negedge clk);

      // start pulsed mid-scan is ignored and not queued.
      chanVal = 4'b1011;
      pulseStart();
      waitValid(1'b1, 4, cyc);
      checkOutput("t6Latency", cyc, 12);
      checkOutput("t6Data",    data, 4'b1011);
      @(negedge clk);
      checkOutput("t6BusyAfter", busy, 0);
      repeat (3) @(negedge clk);
      checkOutput("t6NoQueueBusy",  busy, 0);
      checkOutput("t6NoQueueValid", valid, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream controller for the switch-level 4:1 mux cell with data inputs a,b,c,d, selects s1,s0 and output w.
- Steps the mux selects through all four channels and waits a programmable settle time for the transistor-level delays to resolve.
- Samples w for each channel, packs the four samples into one 4-bit word, and hands the word downstream over a valid/ready handshake.
- Supports one-shot and continuous scanning.

Parameters:
- SETTLE_CYCLES, 2, clock cycles the select is held before w is sampled. Legal range 1..15; 0 is illegal.
- CNT_W, 4, width of the internal settle counter. Must hold SETTLE_CYCLES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle scan request; honoured only in IDLE
- continuous  input  1  1 = start a new scan automatically after each accepted word
- mux_w  input  1  mux output w
- s1  output  1  mux select MSB
- s0  output  1  mux select LSB
- data  output  4  scanned word: data[0]=a (sel 00), data[1]=b (01), data[2]=c (10), data[3]=d (11)
- valid  output  1  data holds a complete scan
- ready  input  1  downstream accepts data when valid&&ready at a rising edge
- busy  output  1  high in SETTLE, SAMPLE and DONE
- err  output  1  sticky: a sample in this scan saw mux_w not 0/1 (X or Z, checked with case equality)

Behaviour:
- Reset (rst=0, immediate, no clock needed):
  - state=IDLE, {s1,s0}=00, data=0, valid=0, busy=0, err=0, idx=0, counter=0, shadow=0.
- Select outputs:
  - All outputs are registered; there is no combinational path from inputs to outputs.
  - {s1,s0}=idx at all times.
- States:
  - IDLE: busy=0. On start=1, at that edge: idx=0, counter=SETTLE_CYCLES-1, err=0, go to SETTLE.
  - SETTLE: if counter==0, go to SAMPLE; else decrement the counter.
  - SAMPLE: one cycle. At its edge, capture mux_w into shadow[idx]. If mux_w is X or Z, capture 0 and set err.
    - If idx<3: increment idx, reload counter=SETTLE_CYCLES-1, go to SETTLE.
    - If idx==3: load data={mux_w,shadow[2:0]}, set valid=1, go to DONE. idx stays 3 until the word is accepted.
  - DONE: hold data, valid and err stable until valid&&ready.
    - At the accepting edge: valid=0.
    - If continuous=1: idx=0, err=0, reload counter, go to SETTLE (back-to-back scan, no idle cycle).
    - Otherwise: idx=0, go to IDLE. err keeps its value until the next scan starts.
- Latency:
  - Each channel takes SETTLE_CYCLES+1 cycles.
  - valid rises 4*(SETTLE_CYCLES+1) edges after the edge that accepts start. With the default this is 12.
- Boundary conditions:
  - start while busy: ignored, no restart and no queueing.
  - start and the DONE handshake in the same cycle: only continuous decides whether a new scan begins.
  - ready=1 while valid=0: no effect.
  - continuous deasserted mid-scan: the current scan completes and the block returns to IDLE after its handshake.
  - continuous asserted while IDLE: no effect until start.
  - Reset mid-scan: everything returns to reset values immediately. No partial word is ever presented. After rst is released, the first edge with start=1 begins a fresh scan.
  - Mux inputs changing mid-scan: each bit reflects w at that channel's sample edge only.
  - idx wraps 3->0 only through DONE, never directly.

Test Plan:
- SETTLE_CYCLES=2, a,b,c,d=1,0,1,1, ready=1, one-shot start -> {s1,s0} reads 00,01,10,11, 3 cycles each; valid=1 exactly 12 edges after start with data=4'b1101 and err=0; next cycle valid=0 and the block is in IDLE.
- Same inputs, ready held 0 for 5 cycles after valid -> data=4'b1101 and valid stay stable, busy=1; one cycle after ready=1 the block is in IDLE and a pulse of start is accepted.
- continuous=1, ready=1, inputs change from 1011 to 0110 between scans -> words 4'b1101 then 4'b0110; the new scan's s1s0=00 appears on the same edge the first word is accepted.
- rst pulsed low during the SETTLE of channel 2 -> s1,s0,data,valid,busy are all 0 without waiting for a clock edge; a new start gives a full correct 12-cycle scan.
- Mux output driven Z (select tri-stated in the bench) on channel 1 -> data[1]=0, err=1 alongside valid; err clears at the next start.
- start pulsed during SETTLE -> ignored; exactly one word is produced and the timing is unchanged.
